// File: rtl/ltc2145_lane_tx.sv
// One LTC2145-style ADC lane serializer: MSB-first words with a frame marker,
// a training run after reset or on request, and idle-word substitution on underflow.
module ltc2145_lane_tx #(
    parameter int               WIDTH         = 14,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 14'h2A3C,
    parameter int               TRAIN_WORDS   = 64,
    parameter logic [WIDTH-1:0] IDLE_WORD     = 14'h2000
) (
    input  logic             sample_clk,
    input  logic             reset,
    input  logic             train_req,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             data_out,
    output logic             frame_out,
    output logic             train_busy,
    output logic             underflow,
    output logic [15:0]      underflow_cnt
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [7:0]    TRAIN_LAST = 8'(TRAIN_WORDS);

    typedef enum logic {TRAIN, DATA} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       train_cnt, train_cnt_next;
    logic [WIDTH-1:0] shift_reg, load_word;
    logic             boundary, take_data, load_train, load_idle;

    assign boundary = (bit_cnt == LAST_BIT);
    assign data_out = shift_reg[WIDTH-1];
    assign s_ready  = boundary && !train_req && (state == DATA || train_cnt == TRAIN_LAST);

    // Word selection for the next boundary; a finished training run falls straight
    // into the data choice so the lane never sees a gap word.
    always_comb begin
        state_next     = state;
        train_cnt_next = train_cnt;
        load_word      = IDLE_WORD;
        load_train     = 1'b0;
        load_idle      = 1'b0;
        take_data      = 1'b0;

        if (state == TRAIN) begin
            if (train_req) begin
                train_cnt_next = 8'd0;
                load_word      = TRAIN_PATTERN;
                load_train     = 1'b1;
            end else if (train_cnt < TRAIN_LAST) begin
                load_word      = train_cnt[0] ? ~TRAIN_PATTERN : TRAIN_PATTERN;
                train_cnt_next = train_cnt + 8'd1;
                load_train     = 1'b1;
            end else begin
                take_data = 1'b1;
            end
        end else begin
            take_data = 1'b1;
        end

        if (take_data) begin
            if (train_req) begin
                state_next     = TRAIN;
                train_cnt_next = 8'd1;
                load_word      = TRAIN_PATTERN;
                load_train     = 1'b1;
            end else if (s_valid) begin
                state_next = DATA;
                load_word  = s_data;
            end else begin
                state_next = DATA;
                load_word  = IDLE_WORD;
                load_idle  = 1'b1;
            end
        end
    end

    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= LAST_BIT;
            state      <= TRAIN;
            train_cnt  <= 8'd0;
            shift_reg  <= '0;
            frame_out  <= 1'b0;
            train_busy <= 1'b1;
            underflow  <= 1'b0;
        end else if (boundary) begin
            bit_cnt    <= '0;
            state      <= state_next;
            train_cnt  <= train_cnt_next;
            shift_reg  <= load_word;
            frame_out  <= 1'b1;
            train_busy <= load_train;
            underflow  <= load_idle;
        end else begin
            bit_cnt    <= bit_cnt + 1'b1;
            shift_reg  <= {shift_reg[WIDTH-2:0], 1'b0};
            frame_out  <= 1'b0;
            underflow  <= 1'b0;
        end
    end

    // Only written on a real increment so the count holds between events.
    always_ff @(posedge sample_clk or negedge reset) begin
        if (!reset) begin
            underflow_cnt <= 16'd0;
        end else if (boundary && load_idle && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ltc2145_lane_tx.sv
// Randomized bench for ltc2145_lane_tx: a word-level lane model predicts every
// output bit each cycle, and literal checks pin the model on the key scenarios.
module tb_ltc2145_lane_tx;

    localparam int          WIDTH = 14;
    localparam int          TW    = 64;
    localparam logic [13:0] TP    = 14'h2A3C;
    localparam logic [13:0] IDLE  = 14'h2000;

    logic        sample_clk = 1'b0;
    logic        reset      = 1'b0;
    logic        train_req  = 1'b0;
    logic [13:0] s_data     = '0;
    logic        s_valid    = 1'b0;
    logic        s_ready, data_out, frame_out, train_busy, underflow;
    logic [15:0] underflow_cnt;

    always #5 sample_clk = ~sample_clk;

    ltc2145_lane_tx dut (
        .sample_clk   (sample_clk),
        .reset        (reset),
        .train_req    (train_req),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .data_out     (data_out),
        .frame_out    (frame_out),
        .train_busy   (train_busy),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Lane model: which word is on the wire and how far into it we are.
    bit          m_training;
    int          m_sent;
    int          m_phase;
    bit          m_have;
    logic [13:0] m_word;
    bit          m_busy;
    bit          m_uf;
    int          m_ufcnt;

    logic [13:0] src_q[$];
    logic [13:0] rx_q[$];
    logic [13:0] rx_asm;
    int          rx_bits;
    bit          valid_en;
    bit          last_ready;
    int          uf_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_training = 1'b1;
        m_sent     = 0;
        m_phase    = WIDTH - 1;
        m_have     = 1'b0;
        m_word     = '0;
        m_busy     = 1'b1;
        m_uf       = 1'b0;
        m_ufcnt    = 0;
    endfunction

    function automatic bit model_ready();
        return (m_phase == WIDTH - 1) && !train_req && (!m_training || m_sent == TW);
    endfunction

    function automatic void model_edge();
        bit take_data;
        m_uf = 1'b0;
        if (m_phase != WIDTH - 1) begin
            m_phase++;
            return;
        end
        m_phase   = 0;
        m_have    = 1'b1;
        take_data = 1'b0;
        if (m_training) begin
            if (train_req) begin
                m_sent = 0;
                m_word = TP;
                m_busy = 1'b1;
            end else if (m_sent < TW) begin
                m_word = (m_sent % 2 == 1) ? ~TP : TP;
                m_sent++;
                m_busy = 1'b1;
            end else begin
                m_training = 1'b0;
                take_data  = 1'b1;
            end
        end else begin
            take_data = 1'b1;
        end
        if (take_data) begin
            if (train_req) begin
                m_training = 1'b1;
                m_sent     = 1;
                m_word     = TP;
                m_busy     = 1'b1;
            end else if (s_valid) begin
                m_word = s_data;
                m_busy = 1'b0;
                void'(src_q.pop_front());
            end else begin
                m_word = IDLE;
                m_busy = 1'b0;
                m_uf   = 1'b1;
                if (m_ufcnt < 16'hFFFF) m_ufcnt++;
            end
        end
    endfunction

    // One clock: drive at the falling edge, check s_ready, advance the model,
    // then compare every registered output at the next falling edge.
    task automatic tick();
        s_valid = valid_en && (src_q.size() > 0);
        s_data  = (src_q.size() > 0) ? src_q[0] : 14'($urandom);
        #1;
        check("s_ready", s_ready, reset ? model_ready() : 1'b0);
        last_ready = s_ready;
        if (reset) model_edge();
        else       model_reset();
        @(posedge sample_clk);
        @(negedge sample_clk);
        check("data_out", data_out, m_have ? m_word[WIDTH-1-m_phase] : 1'b0);
        check("frame_out", frame_out, m_have && m_phase == 0);
        check("train_busy", train_busy, m_busy);
        check("underflow", underflow, m_uf);
        check("underflow_cnt", underflow_cnt, m_ufcnt);
        if (underflow) uf_pulses++;
        if (!reset) begin
            rx_bits = 0;
        end else if (frame_out) begin
            rx_asm  = {13'd0, data_out};
            rx_bits = 1;
        end else if (rx_bits > 0) begin
            rx_asm  = {rx_asm[12:0], data_out};
            rx_bits++;
        end
        if (rx_bits == WIDTH) begin
            rx_q.push_back(rx_asm);
            rx_bits = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int first_ready;
        int gap;
        int guard;

        model_reset();
        valid_en  = 1'b0;
        rx_bits   = 0;
        uf_pulses = 0;
        @(negedge sample_clk);
        repeat (3) tick();

        // Training from release, then the three-word stream and two underflows.
        reset = 1'b1;
        first_ready = 0;
        for (int k = 1; k <= 966; k++) begin
            if (k == 897) begin
                src_q.push_back(14'h0001);
                src_q.push_back(14'h3FFF);
                src_q.push_back(14'h1234);
                valid_en = 1'b1;
            end
            tick();
            if (last_ready && first_ready == 0) first_ready = k;
        end
        src_q.push_back(14'h0ABC);
        repeat (14) tick();

        check("first_ready_edge", first_ready, 897);
        check("rx_count", rx_q.size(), 70);
        check("train_word0", rx_q[0], 14'h2A3C);
        check("train_word1", rx_q[1], 14'h15C3);
        check("train_word63", rx_q[63], 14'h15C3);
        check("stream0", rx_q[64], 14'h0001);
        check("stream1", rx_q[65], 14'h3FFF);
        check("stream2", rx_q[66], 14'h1234);
        check("idle0", rx_q[67], 14'h2000);
        check("idle1", rx_q[68], 14'h2000);
        check("resume", rx_q[69], 14'h0ABC);
        check("uf_count_two", underflow_cnt, 16'd2);
        check("uf_pulses_two", uf_pulses, 2);

        // Random data with random valid gaps.
        repeat (400) begin
            valid_en = ($urandom_range(0, 3) != 0);
            if (src_q.size() < 2) src_q.push_back(14'($urandom));
            tick();
        end

        // Retrain requested mid-word, held until the boundary that samples it.
        valid_en = 1'b1;
        if (src_q.size() < 2) src_q.push_back(14'($urandom));
        guard = 0;
        while (m_phase != 5 && guard < 20) begin tick(); guard++; end
        train_req = 1'b1;
        guard = 0;
        do begin tick(); guard++; end while (m_phase != 0 && guard < 20);
        train_req = 1'b0;
        check("retrain_busy", train_busy, 1'b1);
        gap = 0;
        for (int k = 0; k < 1000; k++) begin
            if (src_q.size() < 2) src_q.push_back(14'($urandom));
            tick();
            gap++;
            if (last_ready) break;
        end
        check("retrain_ready_gap", gap, 896);

        // Asynchronous reset in the middle of a data word.
        repeat (30) begin
            if (src_q.size() < 2) src_q.push_back(14'($urandom));
            valid_en = ($urandom_range(0, 1) != 0);
            tick();
        end
        guard = 0;
        while (m_phase != 6 && guard < 20) begin tick(); guard++; end
        reset = 1'b0;
        #1;
        check("async_data_out", data_out, 1'b0);
        check("async_frame_out", frame_out, 1'b0);
        check("async_s_ready", s_ready, 1'b0);
        check("async_train_busy", train_busy, 1'b1);
        check("async_underflow", underflow, 1'b0);
        check("async_underflow_cnt", underflow_cnt, 16'd0);
        model_reset();
        @(negedge sample_clk);
        repeat (2) tick();
        reset    = 1'b1;
        valid_en = 1'b0;
        src_q.delete();
        rx_q.delete();
        repeat (28) tick();
        check("restart_word0", rx_q[0], 14'h2A3C);
        check("restart_word1", rx_q[1], 14'h15C3);

        // Saturation: preload the counter just below full, then underflow three times.
        repeat (896 - 28) tick();
        force dut.underflow_cnt = 16'hFFFE;
        #1;
        release dut.underflow_cnt;
        m_ufcnt = 16'hFFFE;
        check("forced_cnt", underflow_cnt, 16'hFFFE);
        uf_pulses = 0;
        repeat (42) tick();
        check("sat_pulses", uf_pulses, 3);
        check("sat_cnt", underflow_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ltc2145_lane_tx.md
# ltc2145_lane_tx

Serializer for one LTC2145-style ADC output lane, for the board-test and loopback path. It accepts parallel samples through a valid/ready handshake and emits them MSB-first, one bit per `sample_clk`, with a frame marker on each word's first bit. After reset or on request it sends a training sequence, so that the lane receiver's delay/phase alignment can lock before live data flows.

## Interface
- `WIDTH`, 14: bits per word; legal range 4–16.
- `TRAIN_PATTERN`, 14'h2A3C: training word. Even training words send it as-is; odd training words send its bitwise inverse.
- `TRAIN_WORDS`, 64: number of training words per training run; legal range 2–255.
- `IDLE_WORD`, 14'h2000: word sent on underflow (mid-scale, offset binary).
- `sample_clk`, in, 1: the only clock. All outputs change on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `train_req`, in, 1: level input; sampled only at word boundaries; requests a training run.
- `s_data`, in, WIDTH: sample word.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: the block accepts `s_data` on this edge.
- `data_out`, out, 1: serial lane bit.
- `frame_out`, out, 1: high during the first (MSB) bit of every word.
- `train_busy`, out, 1: high while the word being serialized is a training word.
- `underflow`, out, 1: one-cycle pulse when `IDLE_WORD` is substituted.
- `underflow_cnt`, out, 16: saturating count of underflow events.

## Operation
- Bit counter `bit_cnt` runs 0..WIDTH-1 and then wraps to 0.
  - A word boundary is any edge where `bit_cnt == WIDTH-1`.
  - `bit_cnt` resets to WIDTH-1, so the first edge after reset release is a boundary.
- The shift register loads a new word only at a boundary. Otherwise it shifts left by one bit.
- `data_out` is the registered MSB of the current word. `frame_out` is registered high for the first bit of each word.
- State machine with two states, TRAIN and DATA. Reset state is TRAIN with `train_cnt = 0`.
  - **TRAIN, at a boundary:**
    - If `train_req = 1`: reload `train_cnt` to 0 and load the even training word.
    - Else if `train_cnt < TRAIN_WORDS`: load `TRAIN_PATTERN`, inverted when `train_cnt` is odd, then increment `train_cnt`.
    - Else (`train_cnt == TRAIN_WORDS`): go to DATA and perform the DATA load on this same edge. No gap word is inserted.
  - **DATA, at a boundary:**
    - If `train_req = 1`: go to TRAIN, set `train_cnt` to 1, and load `TRAIN_PATTERN`.
    - Else if `s_valid = 1`: load `s_data`.
    - Else: load `IDLE_WORD`, pulse `underflow`, and increment `underflow_cnt`. The counter saturates at 16'hFFFF.
- `s_ready` is combinational from registers and `train_req`: `bit_cnt == WIDTH-1` && `!train_req` && (state == DATA || `train_cnt == TRAIN_WORDS`).
  - A transfer occurs on an edge where `s_valid && s_ready`.
  - `s_ready` is never high outside a boundary cycle.
- `train_busy` is registered. It goes to 1 at the edge that loads a training word, and to 0 at the edge that loads a data or idle word.
- Reset mid-word aborts the word immediately. The training sequence restarts from word 0.

## Timing
- Reset values: `data_out = 0`, `frame_out = 0`, `s_ready = 0` while `reset` is low, `train_busy = 1`, `underflow = 0`, `underflow_cnt = 0`.
- Latency: a word accepted at edge T has its MSB on `data_out` and `frame_out = 1` just after edge T. Its LSB appears after edge T+WIDTH-1.
- The word period is exactly WIDTH cycles and is continuous. There is never a gap cycle, including across state changes.
- First data acceptance after reset release is at boundary number TRAIN_WORDS+1, i.e. edge (TRAIN_WORDS × WIDTH)+1 after release.
- `train_req` asserted mid-word takes effect only at the next boundary; the current word completes unchanged.
- `train_req` held high keeps the block sending even training words with `train_cnt` pinned.
- `underflow` is high for exactly the cycle after the substituting edge. It does not repeat unless another boundary also underflows.

## Test plan
- **Reset and training.** Release reset with `train_req = 0` and `s_valid = 0`, defaults. Required: 64 words alternating 14'h2A3C / 14'h15C3 MSB-first, `frame_out` every 14 cycles, `train_busy = 1` throughout, then first `s_ready` at edge 897.
- **Streaming.** After training, stream 0x0001, 0x3FFF, 0x1234 with `s_valid` held high. Required: each word appears serialized exactly 14 cycles apart, no underflow, `s_ready` high only on boundary cycles.
- **Underflow.** Drop `s_valid` for two boundaries. Required: two 14'h2000 words, two `underflow` pulses, `underflow_cnt = 2`. The stream then resumes with the next valid word.
- **Retrain.** Pulse `train_req` mid-word during DATA. Required: the current word completes, then a fresh 64-word training run, then the DATA state is re-entered with `s_ready` high.
- **Reset mid-word.** Assert `reset` low for 3 cycles in the middle of a data word. Required: outputs take their reset values asynchronously, and on release training restarts at word 0 (even pattern).
- **Counter saturation.** Preload `underflow_cnt` via a forced bench value of 16'hFFFE, then cause 3 underflows. Required: the counter holds at 16'hFFFF, and an `underflow` pulse still fires on each event.
